// File: rtl/mant_add_arbiter.sv
// Two-requester arbiter sharing one W-bit parallel-prefix mantissa adder, with a one-entry result register.
// Define MANT_ADD_ARB_RR_EN for round-robin tie breaking; otherwise requester 0 always wins ties.

module mant_tree_adder #(
  parameter int W = 25
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] p0;
  logic [W-1:0] gk;
  logic [W-1:0] pk;
  logic [W-1:0] gn;
  logic [W-1:0] pn;
  logic [W:0]   carry;

  // Kogge-Stone prefix: after the last level gk/pk hold the group terms over bits [i:0]
  always_comb begin
    p0 = a ^ b;
    gk = a & b;
    pk = a ^ b;
    gn = '0;
    pn = '0;
    for (int d = 1; d < W; d = d * 2) begin
      gn = gk;
      pn = pk;
      for (int i = d; i < W; i++) begin
        gn[i] = gk[i] | (pk[i] & gk[i-d]);
        pn[i] = pk[i] & pk[i-d];
      end
      gk = gn;
      pk = pn;
    end
    carry[0] = cin;
    for (int i = 0; i < W; i++) begin
      carry[i+1] = gk[i] | (pk[i] & cin);
    end
  end

  assign sum  = p0 ^ carry[W-1:0];
  assign cout = carry[W];

endmodule

module mant_add_arbiter #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req0_sub,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  input  logic         req1_sub,
  output logic         req1_ready,
  output logic         res_valid,
  output logic         res_id,
  output logic [W-1:0] res_sum,
  output logic         res_cout,
  input  logic         res_ready
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]   state;
  logic         free;
  logic         grant0;
  logic         grant1;
  logic         grant;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic         sel_cin;
  logic         sel_sub;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W-1:0] add_sum;
  logic         add_cout;

`ifdef MANT_ADD_ARB_RR_EN
  logic last_grant;
`endif

  assign free = (state == EMPTY) | (res_ready & (state == FULL));

  // Gating with rst_n keeps both readies low while reset is held
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (free && rst_n) begin
`ifdef MANT_ADD_ARB_RR_EN
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
`else
      grant0 = req0_valid;
      grant1 = req1_valid & ~req0_valid;
`endif
    end
  end

  assign grant      = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign res_valid  = (state == FULL);

  assign sel_a   = grant1 ? req1_a   : req0_a;
  assign sel_b   = grant1 ? req1_b   : req0_b;
  assign sel_cin = grant1 ? req1_cin : req0_cin;
  assign sel_sub = grant1 ? req1_sub : req0_sub;

  // Subtraction is a + ~b + 1, so the requester's carry-in is dropped
  assign add_b   = sel_sub ? ~sel_b : sel_b;
  assign add_cin = sel_sub ? 1'b1   : sel_cin;

  mant_tree_adder #(.W(W)) u_adder (
    .a    (sel_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      res_id   <= 1'b0;
      res_sum  <= '0;
      res_cout <= 1'b0;
    end else if (grant) begin
      state    <= FULL;
      res_id   <= grant1;
      res_sum  <= add_sum;
      res_cout <= add_cout;
    end else if (res_ready) begin
      state    <= EMPTY;
    end
  end

`ifdef MANT_ADD_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b0;
    end else if (grant) begin
      last_grant <= grant1;
    end
  end
`endif

endmodule

// File: tb/tb_mant_add_arbiter.sv
// Scoreboard bench for mant_add_arbiter: stimulus pushes expected results, a monitor pops and compares.
// Follows MANT_ADD_ARB_RR_EN the same way as the design to pick the expected tie policy.

module tb_mant_add_arbiter;

  localparam int W = 25;

  typedef struct packed {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_cin = 1'b0, req0_sub = 1'b0, req1_cin = 1'b0, req1_sub = 1'b0;
  logic         req0_ready, req1_ready;
  logic         res_valid, res_id, res_cout;
  logic [W-1:0] res_sum;
  logic         res_ready = 1'b0;

  res_t expq[$];
  int   checks = 0;
  int   failures = 0;
  bit   model_full = 1'b0;
  bit   model_last = 1'b0;

`ifdef MANT_ADD_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk = ~clk;

  mant_add_arbiter #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req0_sub   (req0_sub),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .req1_sub   (req1_sub),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_ready  (res_ready)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain modular arithmetic: subtraction carry means a >= b
  function automatic res_t modelOp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
    res_t r;
    longint unsigned ua, ub, m, total;
    ua = 64'(a);
    ub = 64'(b);
    m  = 64'd1 << W;
    r.id = id;
    if (sub) begin
      total  = (ua + m - ub) % m;
      r.cout = (ua >= ub);
    end else begin
      total  = ua + ub + 64'(cin);
      r.cout = (total >= m);
      total  = total % m;
    end
    r.sum = total[W-1:0];
    return r;
  endfunction

  task automatic applyStimulus(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                               input bit c0, input bit s0,
                               input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                               input bit c1, input bit s1, input bit rr);
    bit free, g0, g1;
    @(posedge clk);
    #1;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0; req0_sub = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1; req1_sub = s1;
    res_ready  = rr;
    @(negedge clk);
    free = !model_full || rr;
    g0 = 1'b0;
    g1 = 1'b0;
    if (free) begin
      if (v0 && v1) begin
        g1 = RR ? !model_last : 1'b0;
        g0 = !g1;
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
    checkOutput("req0_ready", 64'(req0_ready), 64'(g0));
    checkOutput("req1_ready", 64'(req1_ready), 64'(g1));
    if (g0) expq.push_back(modelOp(1'b0, a0, b0, c0, s0));
    if (g1) expq.push_back(modelOp(1'b1, a1, b1, c1, s1));
    if (g0 || g1) model_last = g1;
    model_full = g0 || g1 || (model_full && !rr);
  endtask

  task automatic idle(input bit rr);
    applyStimulus(0, '0, '0, 0, 0, 0, '0, '0, 0, 0, rr);
  endtask

  function automatic logic [W-1:0] randOperand();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = W'(1);
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // Monitor: the held result must match the scoreboard head; res_ready retires it
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      checkOutput("res_valid", 64'(res_valid), 64'(expq.size() != 0));
      if (res_valid && expq.size() != 0) begin
        checkOutput("res_id",   64'(res_id),   64'(expq[0].id));
        checkOutput("res_sum",  64'(res_sum),  64'(expq[0].sum));
        checkOutput("res_cout", 64'(res_cout), 64'(expq[0].cout));
        if (res_ready) void'(expq.pop_front());
      end
    end
  end

  initial begin
    bit tie_exp [4];
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #3;
    checkOutput("rst_req0_ready", 64'(req0_ready), 64'd0);
    checkOutput("rst_req1_ready", 64'(req1_ready), 64'd0);
    checkOutput("rst_res_valid",  64'(res_valid),  64'd0);
    checkOutput("rst_res_sum",    64'(res_sum),    64'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed: single add, subtract, overflow");
    applyStimulus(1, 25'h0FFFFFF, 25'h0000001, 0, 0, 0, '0, '0, 0, 0, 1);
    idle(1);
    applyStimulus(0, '0, '0, 0, 0, 1, 25'd5, 25'd7, 1, 1, 1);
    idle(1);
    applyStimulus(1, 25'h1FFFFFF, 25'h1FFFFFF, 1, 0, 0, '0, '0, 0, 0, 1);
    idle(1);
    idle(1);

    $display("[TB] directed: backpressure");
    applyStimulus(0, '0, '0, 0, 0, 1, 25'h0123456, 25'h0000FFF, 0, 0, 0);
    repeat (3) applyStimulus(1, 25'h1000000, 25'h1000000, 0, 0, 0, '0, '0, 0, 0, 0);
    applyStimulus(1, 25'h1000000, 25'h1000000, 0, 0, 0, '0, '0, 0, 0, 1);
    idle(0);

    $display("[TB] directed: reset while full");
    #2;
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checkOutput("midrst_res_valid",  64'(res_valid),  64'd0);
    checkOutput("midrst_res_id",     64'(res_id),     64'd0);
    checkOutput("midrst_res_sum",    64'(res_sum),    64'd0);
    checkOutput("midrst_res_cout",   64'(res_cout),   64'd0);
    checkOutput("midrst_req0_ready", 64'(req0_ready), 64'd0);
    checkOutput("midrst_req1_ready", 64'(req1_ready), 64'd0);
    expq.delete();
    model_full = 1'b0;
    model_last = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed: ties");
    for (int i = 0; i < 4; i++) tie_exp[i] = RR ? ((i % 2) == 0) : 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, W'(i), W'(10), 0, 0, 1, W'(i), W'(20), 0, 0, 1);
      checkOutput("tie_grant_id", 64'(req1_ready), 64'(tie_exp[i]));
    end
    idle(1);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 1), randOperand(), randOperand(), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 1), randOperand(), randOperand(),
                    $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0);
    end
    repeat (3) idle(1);
    checkOutput("drain_queue_empty", 64'(expq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mant_add_arbiter.md
MANT_ADD_ARBITER -- requirements
Module: mant_add_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 25, the mantissa operand width fixed by the shared tree adder.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req0_valid / req1_valid, input, 1 bit each: requester 0/1 presents an operation.
REQ-005 The block SHALL have port req0_a, req0_b / req1_a, req1_b, input, W bits each: operands.
REQ-006 The block SHALL have port req0_cin / req1_cin, input, 1 bit each: carry-in.
REQ-007 The block SHALL have port req0_sub / req1_sub, input, 1 bit each: 1 = compute a - b.
REQ-008 The block SHALL have port req0_ready / req1_ready, output, 1 bit each: the request is accepted this cycle.
REQ-009 The block SHALL have port res_valid, output, 1 bit: a result is held.
REQ-010 The block SHALL have port res_id, output, 1 bit: the requester that owns the held result.
REQ-011 The block SHALL have port res_sum, output, W bits, and res_cout, output, 1 bit: the held result.
REQ-012 The block SHALL have port res_ready, input, 1 bit: the consumer takes the result.

Function
REQ-013 The block SHALL instantiate exactly one W-bit tree adder and share it between both requesters.
REQ-014 The adder SHALL be fed the granted requester's a, b, cin when sub=0, and a, ~b, 1 when sub=0 is false (that requester's cin ignored).
REQ-015 The FSM SHALL have two states: EMPTY (output register free) and FULL (result held).
REQ-016 The block SHALL report free = (state==EMPTY) | (res_ready & state==FULL).
REQ-017 A grant SHALL occur only when free is 1 and at least one reqN_valid is 1; at most one reqN_ready is high per cycle.
REQ-018 reqN_ready SHALL be combinational: high only in the grant cycle for the selected requester.
REQ-019 On a grant edge, res_sum, res_cout, res_id SHALL load the adder output, and the state SHALL become FULL; latency is 1 cycle from accept to res_valid.
REQ-020 In FULL with res_ready=0, the held result and res_id SHALL be stable, and both reqN_ready SHALL be 0.
REQ-021 In FULL with res_ready=1 and a grant in the same cycle, the block SHALL stay FULL with the new result (back-to-back, no bubble).
REQ-022 In FULL with res_ready=1 and no request, the block SHALL go to EMPTY; res_sum/res_cout keep their last values.
REQ-023 res_ready in EMPTY SHALL be ignored.
REQ-024 res_valid SHALL equal (state==FULL).
REQ-025 Arithmetic SHALL be modulo 2^W with cout the carry out of bit W-1; for subtraction, cout=1 means a >= b.

Reset
REQ-026 When rst_n=0, the block SHALL asynchronously force state EMPTY, res_valid=0, res_id=0, res_sum=0, res_cout=0, and the round-robin pointer to 0.
REQ-027 Reset mid-operation SHALL discard any held result.
REQ-028 reqN_ready SHALL be 0 while rst_n=0.
REQ-029 The first grant after reset release SHALL occur no earlier than the first rising edge with rst_n=1.

Configuration
REQ-030 Macro MANT_ADD_ARB_RR_EN SHALL select the grant policy.
REQ-031 With MANT_ADD_ARB_RR_EN defined, on simultaneous valid requests the block SHALL grant the requester not granted last; a 1-bit last-grant pointer updates on every grant (reset value 0, so requester 1 wins the first tie).
REQ-032 Without MANT_ADD_ARB_RR_EN, requester 0 SHALL always win ties, and no pointer register exists.

Verification
REQ-033 Single add: req0 a=0x0FFFFFF, b=0x0000001, cin=0, res_ready=1 -> req0_ready=1 same cycle; next cycle res_valid=1, id=0, sum=0x1000000, cout=0.
REQ-034 Subtract and overflow: req1 sub=1 a=5 b=7 -> sum=0x1FFFFFE, cout=0. Separately, an add with a=b=0x1FFFFFF and cin=1 -> sum=0x1FFFFFF, cout=1.
REQ-035 Backpressure: result held with res_ready=0 for 3 cycles while req0 is valid -> req0_ready=0 and the result is stable; res_ready=1 -> req0 granted that cycle, and its result appears the next cycle without an EMPTY cycle.
REQ-036 Tie: both requests valid for 4 consecutive grants -> with RR_EN ids 1,0,1,0; without RR_EN ids 0,0,0,0.
REQ-037 Reset mid-op: assert rst_n=0 while FULL -> res_valid=0 immediately (before the next edge) and all outputs 0; after release, a new request completes normally.
